key_priority_encoder: RTL and testbench
=======================================

KEY_PRIORITY_ENCODER -- requirements
Module: key_priority_encoder

Interface
REQ-001 Parameter N_KEYS, default 10, number of key input lines; legal range 2..64.
REQ-002 Parameter ENC_W, default 4, encoded index width; 2**ENC_W SHALL be >= N_KEYS, otherwise elaboration SHALL fail.
REQ-003 Parameter DEBOUNCE, default 4, consecutive stable cycles required to accept a press or a release; legal range 1..255.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  block enable; when low, the block ignores keys.
REQ-007 number  input  N_KEYS  key lines, one bit per key, bit i = key i, active-high.
REQ-008 encoded  output  ENC_W  index of the last accepted key (registered).
REQ-009 valid  output  1  one-cycle strobe marking a newly accepted key.
REQ-010 held  output  1  high while an accepted key remains pressed.
REQ-011 multi  output  1  registered flag: two or more key lines were high at the previous edge.

Function
REQ-012 Priority: the highest-index asserted bit of number SHALL win; idx is that index and any = OR of number.
REQ-013 The FSM SHALL have four states: IDLE, DEBOUNCE, PRESSED and RELEASE.
REQ-014 IDLE: if enable && any, go to DEBOUNCE, latch cand = idx and clear cnt; otherwise remain in IDLE.
REQ-015 DEBOUNCE: if !any or idx != cand, go to IDLE with no output change; otherwise increment cnt.
REQ-016 DEBOUNCE: at the DEBOUNCE-th consecutive matching edge, go to PRESSED, load encoded = cand and set valid = 1 for exactly one cycle.
REQ-017 Latency: for number stable from the edge that leaves IDLE, valid SHALL be high in the cycle after edge DEBOUNCE+1 of that stable input (DEBOUNCE=4: after the 5th edge).
REQ-018 PRESSED: held = 1; a change to a different key SHALL be ignored, with no new valid and encoded unchanged; if !any, go to RELEASE and clear cnt.
REQ-019 RELEASE: held stays 1; DEBOUNCE consecutive !any edges SHALL return to IDLE with held = 0; any key seen SHALL return to PRESSED with cnt cleared and no valid.
REQ-020 A new press SHALL be accepted only after the full path RELEASE -> IDLE, so no auto-repeat occurs.
REQ-021 encoded SHALL hold the last accepted index until the next accepted press.
REQ-022 multi SHALL be registered each edge as enable && (number & (number-1)) != 0, independent of FSM state.
REQ-023 enable low at any edge: the FSM goes to IDLE, cnt = 0, valid = 0, held = 0, multi = 0, and encoded is retained.
REQ-024 cnt SHALL saturate, never wrap; its width SHALL be clog2(DEBOUNCE+1).
REQ-025 valid and held SHALL never be asserted while enable was low at the prior edge.

Reset
REQ-026 reset high at an edge: state = IDLE, cnt = 0, cand = 0, encoded = 0, valid = 0, held = 0, multi = 0.
REQ-027 reset SHALL dominate enable and all inputs; reset asserted mid-debounce or mid-press SHALL abort it with no valid pulse.
REQ-028 The first key may be accepted only after reset has been sampled low; counting starts from the first edge with reset low.

Verification (N_KEYS=10, ENC_W=4, DEBOUNCE=4)
REQ-029 number=10'b0100000000 held for 8 cycles -> valid high for one cycle after the 5th edge, encoded=8, held=1; valid=0 afterwards.
REQ-030 number=10'b0100000100 -> encoded=8, multi=1 one cycle after the input is applied; release then number=10'b0000000100 -> encoded=2.
REQ-031 number=10'b0000001000 for 3 cycles, then 0 -> no valid, encoded unchanged; followed by 1-cycle glitch during RELEASE -> held stays 1, no second valid.
REQ-032 key 5 accepted, switched to key 7 without release -> no valid, encoded=5; full release of 4 cycles, then key 7 for 5 cycles -> valid, encoded=7.
REQ-033 reset pulsed while in DEBOUNCE and later in PRESSED -> all outputs 0 the next cycle, no valid; enable low during PRESSED -> held=0, encoded retained.
REQ-034 Sweep of each single key 0..9 with release gaps -> encoded equals the key index and exactly one valid per key.

Source files
------------

// File: rtl/key_priority_encoder.sv
// key_priority_encoder
//   Debounced priority encoder for a bank of active-high key lines. The
//   highest-index pressed key is the candidate; it is accepted after it has
//   stayed the winner for DEBOUNCE consecutive edges past detection. Releases
//   are debounced the same way, and a new press is accepted only after a full
//   debounced release, so there is no auto-repeat.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high; dominates every other input
//   enable   when low, the block ignores keys and drops held/multi/valid
//   number   key lines, bit i = key i
//   encoded  index of the last accepted key (retained across enable low)
//   valid    one-cycle strobe when a key is accepted
//   held     high while an accepted key is pressed or its release is debouncing
//   multi    registered: two or more key lines were high at the previous edge
module key_priority_encoder #(
  parameter int N_KEYS   = 10,
  parameter int ENC_W    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_KEYS-1:0] number,
  output logic [ENC_W-1:0]  encoded,
  output logic              valid,
  output logic              held,
  output logic              multi
);

  generate
    if (N_KEYS < 2 || N_KEYS > 64) begin : g_bad_keys
      $error("key_priority_encoder: N_KEYS must be in 2..64");
    end
    if ((2 ** ENC_W) < N_KEYS) begin : g_bad_enc
      $error("key_priority_encoder: 2**ENC_W must be >= N_KEYS");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_deb
      $error("key_priority_encoder: DEBOUNCE must be in 1..255");
    end
  endgenerate

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [N_KEYS-1:0] KEY_ONE = N_KEYS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
  logic [ENC_W-1:0]  cand, cand_next;
  logic [ENC_W-1:0]  encoded_next;
  logic              valid_next;
  logic              multi_next;
  logic [ENC_W-1:0]  idx;
  logic              any;

  // Highest asserted bit wins: later iterations overwrite earlier ones.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (number[i]) idx = ENC_W'(i);
    end
  end

  assign any = |number;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_next = enable && ((number & (number - KEY_ONE)) != '0);

  // Saturating increment.
  assign cnt_inc = (cnt < CNT_MAX) ? cnt + CNT_ONE : cnt;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    cand_next    = cand;
    encoded_next = encoded;
    valid_next   = 1'b0;
    if (!enable) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            state_next = S_DEBOUNCE;
            cand_next  = idx;
            cnt_next   = '0;
          end
        end
        S_DEBOUNCE: begin
          if (!any || idx != cand) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next   = S_PRESSED;
            encoded_next = cand;
            valid_next   = 1'b1;
            cnt_next     = cnt_inc;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        S_PRESSED: begin
          // A different key while pressed is deliberately ignored.
          if (!any) begin
            state_next = S_RELEASE;
            cnt_next   = '0;
          end
        end
        S_RELEASE: begin
          if (any) begin
            state_next = S_PRESSED;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cand    <= '0;
      encoded <= '0;
      valid   <= 1'b0;
      multi   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      cand    <= cand_next;
      encoded <= encoded_next;
      valid   <= valid_next;
      multi   <= multi_next;
    end
  end

  // Decoded from the state register, so it is effectively registered.
  always_comb begin
    held = (state == S_PRESSED) || (state == S_RELEASE);
  end

endmodule

// File: tb/tb_key_priority_encoder.sv
module tb_key_priority_encoder;

  localparam int NK  = 10;
  localparam int EW  = 4;
  localparam int DEB = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [NK-1:0] number;
  logic [EW-1:0] encoded;
  logic          valid;
  logic          held;
  logic          multi;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;
  int valid_count = 0;

  key_priority_encoder #(
    .N_KEYS  (NK),
    .ENC_W   (EW),
    .DEBOUNCE(DEB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .number (number),
    .encoded(encoded),
    .valid  (valid),
    .held   (held),
    .multi  (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int top_key(input logic [NK-1:0] v);
    int t;
    t = -1;
    for (int i = 0; i < NK; i++) if (v[i]) t = i;
    return t;
  endfunction

  // Behavioural model: run length of the current winner while idle, quiet
  // length while a key is accepted.
  bit m_active, m_valid, m_multi;
  int m_run, m_quiet, m_cand, m_enc;

  always @(posedge clk) begin
    int t;
    t = top_key(number);
    m_valid = 0;
    if (reset) begin
      m_active = 0; m_run = 0; m_quiet = 0; m_cand = 0; m_enc = 0; m_multi = 0;
    end else begin
      m_multi = enable && ($countones(number) >= 2);
      if (!enable) begin
        m_active = 0; m_run = 0; m_quiet = 0;
      end else if (m_active) begin
        if (t >= 0) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet == DEB + 1) begin m_active = 0; m_quiet = 0; end
        end
      end else if (m_run > 0) begin
        if (t == m_cand) begin
          m_run++;
          if (m_run == DEB + 1) begin
            m_active = 1; m_enc = m_cand; m_valid = 1; m_run = 0;
          end
        end else m_run = 0;
      end else if (t >= 0) begin
        m_cand = t; m_run = 1;
      end
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("encoded", 32'(encoded), 32'(m_enc));
      check("valid",   32'(valid),   32'(m_valid));
      check("held",    32'(held),    32'(m_active));
      check("multi",   32'(multi),   32'(m_multi));
      if (valid === 1'b1) valid_count++;
    end
  end

  // Apply inputs for n rising edges; returns just after a falling edge.
  task automatic drive(input logic r, input logic e, input logic [NK-1:0] num,
                       input int n);
    reset = r; enable = e; number = num;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input int k, input int n);
    logic [NK-1:0] v;
    v = '0;
    v[k] = 1'b1;
    drive(0, 1, v, n);
  endtask

  initial begin
    int vc0;
    reset = 1; enable = 0; number = '0;
    @(posedge clk);
    chk_en = 1;
    drive(1, 0, '0, 2);
    check("reset_encoded", 32'(encoded), 0);
    check("reset_held",    32'(held),    0);
    check("reset_multi",   32'(multi),   0);

    // Single key 8: valid appears only after the 5th edge.
    drive(0, 1, 10'b0100000000, 4);
    check("lat_valid_early", 32'(valid), 0);
    drive(0, 1, 10'b0100000000, 1);
    check("lat_valid", 32'(valid),   1);
    check("lat_enc",   32'(encoded), 8);
    check("lat_held",  32'(held),    1);
    drive(0, 1, 10'b0100000000, 3);
    check("lat_valid_after", 32'(valid), 0);
    drive(0, 1, '0, 6);
    check("rel_held", 32'(held), 0);

    // Two keys: 8 wins, multi one cycle after the input.
    drive(0, 1, 10'b0100000100, 1);
    check("multi_set", 32'(multi), 1);
    drive(0, 1, 10'b0100000100, 4);
    check("multi_enc", 32'(encoded), 8);
    drive(0, 1, '0, 6);
    drive(0, 1, 10'b0000000100, 5);
    check("key2_enc", 32'(encoded), 2);
    drive(0, 1, '0, 6);

    // Short press of key 3 is rejected.
    press(3, 3);
    drive(0, 1, '0, 2);
    check("short_enc", 32'(encoded), 2);
    // Winner change during debounce restarts detection.
    press(1, 2);
    drive(0, 1, 10'b1000000010, 2);
    drive(0, 1, '0, 2);
    // Accept key 3, then a one-cycle glitch during release.
    press(3, 5);
    check("k3_enc", 32'(encoded), 3);
    drive(0, 1, '0, 2);
    press(3, 1);
    check("glitch_held", 32'(held), 1);
    check("glitch_valid", 32'(valid), 0);
    drive(0, 1, '0, 2);
    check("glitch_held2", 32'(held), 1);
    drive(0, 1, '0, 4);
    check("glitch_rel", 32'(held), 0);

    // Key 5 accepted, slide to key 7 without release: ignored.
    press(5, 5);
    press(7, 6);
    check("slide_enc",  32'(encoded), 5);
    check("slide_held", 32'(held),    1);
    drive(0, 1, '0, 6);
    press(7, 5);
    check("k7_valid", 32'(valid),   1);
    check("k7_enc",   32'(encoded), 7);
    drive(0, 1, '0, 6);

    // Reset mid-debounce and mid-press.
    press(4, 3);
    drive(1, 1, 10'b0000010000, 1);
    check("rst_deb_enc",   32'(encoded), 0);
    check("rst_deb_valid", 32'(valid),   0);
    press(4, 5);
    check("post_rst_enc", 32'(encoded), 4);
    drive(1, 1, 10'b0000010000, 1);
    check("rst_prs_held", 32'(held),    0);
    check("rst_prs_enc",  32'(encoded), 0);
    press(4, 3);
    drive(0, 1, '0, 6);

    // Enable low during press: held drops, encoded retained, multi masked.
    press(6, 5);
    drive(0, 0, 10'b0001000001, 1);
    check("en_held",  32'(held),    0);
    check("en_enc",   32'(encoded), 6);
    check("en_multi", 32'(multi),   0);
    drive(0, 0, 10'b0001000001, 2);
    drive(0, 1, '0, 2);

    // Sweep every key with release gaps.
    for (int k = 0; k < NK; k++) begin
      vc0 = valid_count;
      press(k, 6);
      drive(0, 1, '0, 6);
      check("sweep_enc",   32'(encoded),          32'(k));
      check("sweep_count", 32'(valid_count - vc0), 1);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
